// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word and the state reported by the RAM.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/diaosi_types_pkg.sv
// Arbiter FSM encoding. Kept as plain constants so older tools and waveform
// scripts that decode the raw 2-bit value keep working. Prefixed names avoid a
// clash with the ERROR member of ramstate_t when both packages are imported.
package diaosi_types_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE  = 2'd0;
  localparam arb_state_t ARB_DATA  = 2'd1;
  localparam arb_state_t ARB_INSTR = 2'd2;
  localparam arb_state_t ARB_ERROR = 2'd3;

endpackage

// File: rtl/ram_timeout_counter.sv
// Saturating cycle counter for an outstanding RAM request. expired_o is raised
// during the TIMEOUT-th consecutive enabled cycle, so the owner can leave the
// request state on that edge having spent exactly TIMEOUT cycles in it.
module ram_timeout_counter #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear has priority, otherwise count up and stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q >= LIMIT);

endmodule

// File: rtl/mem_request_arbiter.sv
// Cache-side responder: arbitrates datapath fetch and data requests onto one
// single-port RAM, data first. RAM strobes/address/store data are registered
// and held for the whole access; hits are combinational on the ACCESS cycle.
module mem_request_arbiter
  import cpu_types_pkg::*;
  import diaosi_types_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  word_t       imemaddr,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  word_t       dmemaddr,
  input  word_t       dmemstore,
  input  logic        halt,
  output logic        ihit,
  output word_t       imemload,
  output logic        dhit,
  output word_t       dmemload,
  output logic        ramREN,
  output logic        ramWEN,
  output word_t       ramaddr,
  output word_t       ramstore,
  input  word_t       ramload,
  input  ramstate_t   ramstate,
  output logic        arb_err
);

  arb_state_t state_q, state_d;
  logic       ramren_q, ramren_d;
  logic       ramwen_q, ramwen_d;
  word_t      ramaddr_q, ramaddr_d;
  word_t      ramstore_q, ramstore_d;
  logic       arb_err_q, arb_err_d;

  logic       cnt_en, cnt_clr, cnt_expired;

  // Counter runs only while a request is outstanding and is zeroed on every
  // return to IDLE (and by reset), so each request gets a fresh budget.
  assign cnt_en  = (state_q == ARB_DATA) || (state_q == ARB_INSTR);
  assign cnt_clr = (state_d == ARB_IDLE);

  ram_timeout_counter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .CLK       (CLK),
    .nRST      (nRST),
    .clr_i     (cnt_clr),
    .en_i      (cnt_en),
    .expired_o (cnt_expired)
  );

  // Arbitration, completion and error detection for the current request.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    ramren_d   = ramren_q;
    ramwen_d   = ramwen_q;
    ramaddr_d  = ramaddr_q;
    ramstore_d = ramstore_q;
    arb_err_d  = arb_err_q;
    ihit       = 1'b0;
    dhit       = 1'b0;
    imemload   = '0;
    dmemload   = '0;

    case (state_q)
      ARB_IDLE: begin
        if (dmemREN || dmemWEN) begin
          // A simultaneous read+write request is treated as a write.
          state_d    = ARB_DATA;
          ramren_d   = dmemREN && !dmemWEN;
          ramwen_d   = dmemWEN;
          ramaddr_d  = dmemaddr;
          ramstore_d = dmemstore;
        end else if (imemREN && !halt) begin
          state_d    = ARB_INSTR;
          ramren_d   = 1'b1;
          ramwen_d   = 1'b0;
          ramaddr_d  = imemaddr;
          ramstore_d = '0;
        end
      end

      ARB_DATA, ARB_INSTR: begin
        if (ramstate == ACCESS) begin
          // The RAM cycle always completes; the hit is only reported if the
          // datapath is still asking for it.
          if (state_q == ARB_DATA) begin
            dhit     = dmemREN || dmemWEN;
            dmemload = dhit ? ramload : '0;
          end else begin
            ihit     = imemREN;
            imemload = ihit ? ramload : '0;
          end
          state_d  = ARB_IDLE;
          ramren_d = 1'b0;
          ramwen_d = 1'b0;
        end else if ((ramstate == ERROR) || cnt_expired) begin
          state_d   = ARB_ERROR;
          ramren_d  = 1'b0;
          ramwen_d  = 1'b0;
          arb_err_d = 1'b1;
        end
      end

      default: begin
        // ARB_ERROR absorbs until reset with the strobes forced low.
        ramren_d = 1'b0;
        ramwen_d = 1'b0;
      end
    endcase
  end

  // State and request registers; reset drops any in-flight access.
  always_ff @(posedge CLK) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (!nRST) begin
      state_q    <= ARB_IDLE;
      ramren_q   <= 1'b0;
      ramwen_q   <= 1'b0;
      ramaddr_q  <= '0;
      ramstore_q <= '0;
      arb_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ramren_q   <= ramren_d;
      ramwen_q   <= ramwen_d;
      ramaddr_q  <= ramaddr_d;
      ramstore_q <= ramstore_d;
      arb_err_q  <= arb_err_d;
    end
  end

  assign ramREN   = ramren_q;
  assign ramWEN   = ramwen_q;
  assign ramaddr  = ramaddr_q;
  assign ramstore = ramstore_q;
  assign arb_err  = arb_err_q;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed bench for mem_request_arbiter. Stimulus pushes the expected hits into
// a scoreboard queue; a monitor on the falling edge pops and compares whenever
// the DUT raises ihit/dhit. Strobe/address/error checks are made inline.
module tb_mem_request_arbiter;
  import cpu_types_pkg::*;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      imemREN, dmemREN, dmemWEN, halt;
  word_t     imemaddr, dmemaddr, dmemstore, ramload;
  ramstate_t ramstate;
  logic      ihit, dhit, ramREN, ramWEN, arb_err;
  word_t     imemload, dmemload, ramaddr, ramstore;

  typedef struct packed {
    logic  is_data;
    word_t load;
  } hit_t;

  hit_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic mon_en   = 1'b0;

  always #5 CLK = ~CLK;

  mem_request_arbiter #(.TIMEOUT(4), .CNT_W(8)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .dmemREN   (dmemREN),
    .dmemWEN   (dmemWEN),
    .dmemaddr  (dmemaddr),
    .dmemstore (dmemstore),
    .halt      (halt),
    .ihit      (ihit),
    .imemload  (imemload),
    .dhit      (dhit),
    .dmemload  (dmemload),
    .ramREN    (ramREN),
    .ramWEN    (ramWEN),
    .ramaddr   (ramaddr),
    .ramstore  (ramstore),
    .ramload   (ramload),
    .ramstate  (ramstate),
    .arb_err   (arb_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    imemREN = 1'b0; imemaddr = '0;
    dmemREN = 1'b0; dmemWEN = 1'b0; dmemaddr = '0; dmemstore = '0;
    halt = 1'b0; ramstate = FREE; ramload = '0;
  endtask

  task automatic chk_ram(input string tag, input logic ren, input logic wen,
                         input word_t addr, input word_t store);
    check({tag, "_ramREN"},   ramREN,   ren);
    check({tag, "_ramWEN"},   ramWEN,   wen);
    check({tag, "_ramaddr"},  ramaddr,  addr);
    check({tag, "_ramstore"}, ramstore, store);
  endtask

  task automatic push_hit(input logic is_data, input word_t load);
    hit_t h;
    h.is_data = is_data;
    h.load    = load;
    exp_q.push_back(h);
  endtask

  // Monitor: every hit must match the next scoreboard entry; loads must be 0
  // whenever their hit is low.
  initial begin
    hit_t e;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if (ihit || dhit) begin
          check("hit_onehot", {31'd0, ihit & dhit}, 32'd0);
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_hit: ihit=%0b dhit=%0b, expected no hit", ihit, dhit);
          end else begin
            e = exp_q.pop_front();
            check("hit_kind", {31'd0, dhit}, {31'd0, e.is_data});
            check("hit_load", dhit ? dmemload : imemload, e.load);
          end
        end
        if (!ihit) check("imemload_zero", imemload, 32'd0);
        if (!dhit) check("dmemload_zero", dmemload, 32'd0);
      end
    end
  end

  initial begin
    nRST = 1'b0;
    idle_inputs();
    repeat (2) tick();
    mid();
    chk_ram("reset", 1'b0, 1'b0, 32'd0, 32'd0);
    check("reset_arb_err", arb_err, 1'b0);
    check("reset_ihit", ihit, 1'b0);
    check("reset_dhit", dhit, 1'b0);
    mon_en = 1'b1;
    tick();
    nRST = 1'b1;

    // 1: fetch with no stall, hit on the second cycle.
    imemREN = 1'b1; imemaddr = 32'h40;
    push_hit(1'b0, 32'h2402000A);
    mid();
    check("t1_arb_cycle_ramREN", ramREN, 1'b0);
    tick();
    ramstate = ACCESS; ramload = 32'h2402000A;
    mid();
    chk_ram("t1", 1'b1, 1'b0, 32'h40, 32'h0);
    check("t1_ihit", ihit, 1'b1);
    tick();
    imemREN = 1'b0; ramstate = FREE; ramload = '0;
    mid();
    check("t1_ramREN_cleared", ramREN, 1'b0);

    // 2: data beats a simultaneous fetch; fetch is granted at the next IDLE.
    tick();
    imemREN = 1'b1; imemaddr = 32'h44;
    dmemREN = 1'b1; dmemaddr = 32'h80;
    push_hit(1'b1, 32'h11111111);
    push_hit(1'b0, 32'h22222222);
    tick();
    ramstate = ACCESS; ramload = 32'h11111111;
    mid();
    chk_ram("t2_data", 1'b1, 1'b0, 32'h80, 32'h0);
    check("t2_dhit", dhit, 1'b1);
    tick();
    dmemREN = 1'b0; ramstate = FREE; ramload = '0;
    mid();
    check("t2_idle_ramREN", ramREN, 1'b0);
    tick();
    ramstate = ACCESS; ramload = 32'h22222222;
    mid();
    chk_ram("t2_instr", 1'b1, 1'b0, 32'h44, 32'h0);
    check("t2_ihit", ihit, 1'b1);
    tick();
    imemREN = 1'b0; ramstate = FREE; ramload = '0;

    // 3: store held through 3 BUSY cycles, hit on ACCESS.
    tick();
    dmemWEN = 1'b1; dmemaddr = 32'h100; dmemstore = 32'hDEADBEEF;
    push_hit(1'b1, 32'h5A5A5A5A);
    tick();
    ramstate = BUSY;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk_ram("t3_busy", 1'b0, 1'b1, 32'h100, 32'hDEADBEEF);
      check("t3_busy_dhit", dhit, 1'b0);
      tick();
    end
    ramstate = ACCESS; ramload = 32'h5A5A5A5A;
    mid();
    chk_ram("t3_access", 1'b0, 1'b1, 32'h100, 32'hDEADBEEF);
    check("t3_dhit", dhit, 1'b1);
    tick();
    dmemWEN = 1'b0; dmemstore = '0; ramstate = FREE; ramload = '0;
    mid();
    check("t3_ramWEN_cleared", ramWEN, 1'b0);

    // 4: store issued before halt completes; halted fetch never reaches RAM.
    tick();
    dmemWEN = 1'b1; dmemaddr = 32'h104; dmemstore = 32'h12345678;
    push_hit(1'b1, 32'hCAFEF00D);
    tick();
    halt = 1'b1; imemREN = 1'b1; imemaddr = 32'h300; ramstate = BUSY;
    mid();
    chk_ram("t4_store", 1'b0, 1'b1, 32'h104, 32'h12345678);
    tick();
    ramstate = ACCESS; ramload = 32'hCAFEF00D;
    mid();
    check("t4_dhit", dhit, 1'b1);
    tick();
    dmemWEN = 1'b0; dmemstore = '0; ramstate = FREE; ramload = '0;
    for (int i = 0; i < 4; i++) begin
      mid();
      check("t4_halt_no_ramREN", ramREN, 1'b0);
      tick();
    end
    halt = 1'b0; imemREN = 1'b0;

    // 5: RAM stuck BUSY -> ERROR after 4 cycles; absorbing until reset.
    tick();
    imemREN = 1'b1; imemaddr = 32'h200;
    tick();
    ramstate = BUSY;
    for (int i = 0; i < 4; i++) begin
      mid();
      check("t5_busy_ramREN", ramREN, 1'b1);
      check("t5_busy_arb_err", arb_err, 1'b0);
      tick();
    end
    mid();
    check("t5_err_arb_err", arb_err, 1'b1);
    check("t5_err_ramREN", ramREN, 1'b0);
    check("t5_err_ramWEN", ramWEN, 1'b0);
    tick();
    ramstate = ACCESS; ramload = 32'hFFFFFFFF; dmemREN = 1'b1;
    mid();
    check("t5_absorb_ramREN", ramREN, 1'b0);
    check("t5_absorb_arb_err", arb_err, 1'b1);
    tick();
    nRST = 1'b0; imemREN = 1'b0; dmemREN = 1'b0; ramstate = FREE; ramload = '0;
    tick();
    nRST = 1'b1;
    mid();
    check("t5_reset_arb_err", arb_err, 1'b0);
    check("t5_reset_ramREN", ramREN, 1'b0);

    // 5b: RAM reports ERROR during a data read.
    tick();
    dmemREN = 1'b1; dmemaddr = 32'h180;
    tick();
    ramstate = ERROR;
    mid();
    check("t5b_ramREN", ramREN, 1'b1);
    check("t5b_pre_arb_err", arb_err, 1'b0);
    tick();
    dmemREN = 1'b0; ramstate = FREE;
    mid();
    check("t5b_arb_err", arb_err, 1'b1);
    check("t5b_err_ramREN", ramREN, 1'b0);
    tick();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    mid();
    check("t5b_reset_arb_err", arb_err, 1'b0);

    // 6: reset while BUSY drops the access; no late dhit.
    tick();
    dmemREN = 1'b1; dmemaddr = 32'h300;
    tick();
    ramstate = BUSY; nRST = 1'b0;
    mid();
    check("t6_busy_ramREN", ramREN, 1'b1);
    check("t6_busy_ramaddr", ramaddr, 32'h300);
    tick();
    nRST = 1'b1; dmemREN = 1'b0; ramstate = ACCESS; ramload = 32'h77777777;
    mid();
    chk_ram("t6_after_reset", 1'b0, 1'b0, 32'h0, 32'h0);
    check("t6_arb_err", arb_err, 1'b0);
    check("t6_no_dhit", dhit, 1'b0);
    tick();
    ramstate = FREE; ramload = '0;

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
